exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_exc_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt commit controller: prioritises MEM-stage events, drives CP0 and flush/redirect.
// Latency: event at edge T -> commit pulse + flush in T+1, fetch redirect + flush in T+2.
// No backpressure: one event per 3-cycle sequence; MEM inputs are ignored while a sequence runs.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_ds_i,
    input  logic        if_adel_i,
    input  logic        ri_i,
    input  logic        sys_i,
    input  logic        bp_i,
    input  logic        ov_i,
    input  logic        ld_adel_i,
    input  logic        st_ades_i,
    input  logic [31:0] mem_addr_i,
    input  logic        eret_i,
    input  logic [5:0]  hw_int_raw_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic [5:0]  hw_int_o,
    output logic        exc_valid_o,
    output logic [4:0]  exc_code_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_in_ds_o,
    output logic [31:0] exc_badvaddr_o,
    output logic        eret_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    state_t      state_q, state_d;
    logic [5:0]  sync_q [SYNC_STAGES];
    logic [5:0]  sync_d [SYNC_STAGES];
    logic        exc_valid_q, exc_valid_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic        exc_in_ds_q, exc_in_ds_d;
    logic [31:0] exc_badvaddr_q, exc_badvaddr_d;
    logic        eret_q, eret_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] tgt_q, tgt_d;

    logic        int_pending;
    logic        exc_any;
    logic [4:0]  code_sel;
    logic [31:0] badv_sel;
    logic        unused_cp0_bits;

    assign unused_cp0_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    // Synchronizer chain: shifts every cycle regardless of FSM state
    always_comb begin
        sync_d[0] = hw_int_raw_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign hw_int_o = sync_q[SYNC_STAGES-1];

    // Interrupts are only taken with IE set, outside exception level, and an unmasked line pending
    assign int_pending = status_i[0] && !status_i[1] && ((cause_i[15:8] & status_i[15:8]) != 8'h00);
    assign exc_any     = int_pending || if_adel_i || ri_i || sys_i || bp_i || ov_i
                         || ld_adel_i || st_ades_i;

    // Priority encoder: ExcCode and bad address of the highest-priority exception class
    always_comb begin
        code_sel = 5'h00;
        badv_sel = 32'h0;
        if (int_pending) begin
            code_sel = 5'h00;
        end else if (if_adel_i) begin
            code_sel = 5'h04;
            badv_sel = mem_pc_i;
        end else if (ri_i) begin
            code_sel = 5'h0A;
        end else if (sys_i) begin
            code_sel = 5'h08;
        end else if (bp_i) begin
            code_sel = 5'h09;
        end else if (ov_i) begin
            code_sel = 5'h0C;
        end else if (ld_adel_i) begin
            code_sel = 5'h04;
            badv_sel = mem_addr_i;
        end else if (st_ades_i) begin
            code_sel = 5'h05;
            badv_sel = mem_addr_i;
        end
    end

    // FSM next state and next values of all registered outputs (outputs idle at zero)
    always_comb begin
        state_d          = state_q;
        tgt_d            = tgt_q;
        exc_valid_d      = 1'b0;
        exc_code_d       = 5'h00;
        exc_pc_d         = 32'h0;
        exc_in_ds_d      = 1'b0;
        exc_badvaddr_d   = 32'h0;
        eret_d           = 1'b0;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = 32'h0;
        case (state_q)
            IDLE: begin
                if (mem_valid_i && (exc_any || eret_i)) begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                    if (exc_any) begin
                        // Any exception class wins over ERET, even at exception level
                        exc_valid_d    = 1'b1;
                        exc_code_d     = code_sel;
                        exc_pc_d       = mem_pc_i;
                        exc_in_ds_d    = mem_in_ds_i;
                        exc_badvaddr_d = badv_sel;
                        tgt_d          = EXC_VECTOR;
                    end else begin
                        eret_d = 1'b1;
                        tgt_d  = epc_i;
                    end
                end
            end
            FLUSH: begin
                state_d          = REDIRECT;
                flush_d          = 1'b1;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = tgt_q;
            end
            REDIRECT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, synchronizer and output registers; reset aborts any sequence in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 6'h00;
            end
            tgt_q            <= 32'h0;
            exc_valid_q      <= 1'b0;
            exc_code_q       <= 5'h00;
            exc_pc_q         <= 32'h0;
            exc_in_ds_q      <= 1'b0;
            exc_badvaddr_q   <= 32'h0;
            eret_q           <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
        end else begin
            state_q          <= state_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            tgt_q            <= tgt_d;
            exc_valid_q      <= exc_valid_d;
            exc_code_q       <= exc_code_d;
            exc_pc_q         <= exc_pc_d;
            exc_in_ds_q      <= exc_in_ds_d;
            exc_badvaddr_q   <= exc_badvaddr_d;
            eret_q           <= eret_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign exc_valid_o      = exc_valid_q;
    assign exc_code_o       = exc_code_q;
    assign exc_pc_o         = exc_pc_q;
    assign exc_in_ds_o      = exc_in_ds_q;
    assign exc_badvaddr_o   = exc_badvaddr_q;
    assign eret_o           = eret_q;
    assign flush_o          = flush_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: expected commits queued at stimulus time, compared when the DUT commits.
// Latency: commit expected one cycle after the accepting edge, redirect one cycle later.
// No backpressure in the DUT; the bench spaces events by the sequence length.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam int          NS  = 2;

    localparam logic [6:0] F_IF = 7'h40, F_RI = 7'h20, F_SYS = 7'h10, F_BP = 7'h08,
                           F_OV = 7'h04, F_LD = 7'h02, F_ST = 7'h01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_pc_i = '0;
    logic        mem_in_ds_i = 1'b0;
    logic        if_adel_i = 1'b0, ri_i = 1'b0, sys_i = 1'b0, bp_i = 1'b0;
    logic        ov_i = 1'b0, ld_adel_i = 1'b0, st_ades_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic        eret_i = 1'b0;
    logic [5:0]  hw_int_raw_i = '0;
    logic [31:0] status_i = 32'h00400400;
    logic [31:0] cause_i;
    logic [31:0] epc_i = '0;
    logic [5:0]  hw_int_o;
    logic        exc_valid_o;
    logic [4:0]  exc_code_o;
    logic [31:0] exc_pc_o;
    logic        exc_in_ds_o;
    logic [31:0] exc_badvaddr_o;
    logic        eret_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    // CP0 stand-in: Cause.IP7..IP2 follow the synchronized hardware lines
    assign cause_i = {16'h0000, hw_int_o, 10'b0};

    exc_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(NS)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_in_ds_i(mem_in_ds_i),
        .if_adel_i(if_adel_i), .ri_i(ri_i), .sys_i(sys_i), .bp_i(bp_i), .ov_i(ov_i),
        .ld_adel_i(ld_adel_i), .st_ades_i(st_ades_i), .mem_addr_i(mem_addr_i),
        .eret_i(eret_i), .hw_int_raw_i(hw_int_raw_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
        .hw_int_o(hw_int_o), .exc_valid_o(exc_valid_o), .exc_code_o(exc_code_o),
        .exc_pc_o(exc_pc_o), .exc_in_ds_o(exc_in_ds_o), .exc_badvaddr_o(exc_badvaddr_o),
        .eret_o(eret_o), .flush_o(flush_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] badv;
        logic [31:0] rpc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic redir_due = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic is_exc, input logic [4:0] code, input logic [31:0] pc,
                            input logic ds, input logic [31:0] badv, input logic [31:0] rpc);
        exp_t e;
        e.is_exc = is_exc; e.code = code; e.pc = pc; e.ds = ds; e.badv = badv; e.rpc = rpc;
        exp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        mem_valid_i = 1'b0; mem_pc_i = '0; mem_in_ds_i = 1'b0; mem_addr_i = '0; eret_i = 1'b0;
        {if_adel_i, ri_i, sys_i, bp_i, ov_i, ld_adel_i, st_ades_i} = 7'h00;
    endtask

    // Entered just after a rising edge; holds the instruction for 'edges' edges, then idles
    task automatic present(input logic [6:0] flags, input logic er, input logic valid,
                           input logic [31:0] pc, input logic [31:0] addr, input logic ds,
                           input int edges);
        mem_valid_i = valid; mem_pc_i = pc; mem_addr_i = addr; mem_in_ds_i = ds; eret_i = er;
        {if_adel_i, ri_i, sys_i, bp_i, ov_i, ld_adel_i, st_ades_i} = flags;
        repeat (edges) @(posedge clk);
        #1 clear_inputs();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: every commit must match the oldest expectation and be followed by its redirect
    always @(negedge clk) begin
        if (rst) begin
            redir_due = 1'b0;
        end else begin
            if (redir_due) begin
                check("redir_vld", redirect_valid_o, 1);
                check("redir_pc", redirect_pc_o, cur.rpc);
                check("redir_flush", flush_o, 1);
                redir_due = 1'b0;
            end else if (redirect_valid_o) begin
                check("spurious_redir", redirect_valid_o, 0);
            end
            if (exc_valid_o || eret_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_commit", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("exc_vld", exc_valid_o, cur.is_exc);
                    check("eret", eret_o, !cur.is_exc);
                    check("commit_flush", flush_o, 1);
                    if (cur.is_exc) begin
                        check("code", exc_code_o, cur.code);
                        check("exc_pc", exc_pc_o, cur.pc);
                        check("in_ds", exc_in_ds_o, cur.ds);
                        check("badvaddr", exc_badvaddr_o, cur.badv);
                    end
                    redir_due = 1'b1;
                end
            end
        end
    end

    initial begin
        hw_int_raw_i = 6'h3F;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_hw_int", hw_int_o, 0);
        check("rst_exc_vld", exc_valid_o, 0);
        check("rst_eret", eret_o, 0);
        check("rst_flush", flush_o, 0);
        check("rst_redir_vld", redirect_valid_o, 0);
        check("rst_redir_pc", redirect_pc_o, 0);
        check("rst_code_pc", {exc_pc_o[26:0], exc_code_o}, 0);
        hw_int_raw_i = 6'h00;
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Overflow in a delay slot: raw PC reported
        push_exp(1, 5'h0C, 32'h80001000, 1, 0, VEC);
        present(F_OV, 0, 1, 32'h80001000, 0, 1, 1);

        // ERET returns to the EPC captured at acceptance
        epc_i = 32'h80002004;
        push_exp(0, 0, 0, 0, 0, 32'h80002004);
        present(7'h00, 1, 1, 32'h80000100, 0, 0, 1);
        epc_i = 32'h0;

        // Priority and bad-address selection
        push_exp(1, 5'h0A, 32'h80000200, 0, 0, VEC);
        present(F_RI | F_OV | F_ST, 0, 1, 32'h80000200, 32'h3, 0, 1);
        push_exp(1, 5'h04, 32'h80000204, 0, 32'h80000001, VEC);
        present(F_LD, 0, 1, 32'h80000204, 32'h80000001, 0, 1);
        push_exp(1, 5'h04, 32'h80000002, 0, 32'h80000002, VEC);
        present(F_IF | F_SYS | F_LD, 0, 1, 32'h80000002, 32'h1234, 0, 1);
        push_exp(1, 5'h08, 32'h80000300, 0, 0, VEC);
        present(F_SYS | F_BP, 1, 1, 32'h80000300, 32'h7, 0, 1);
        push_exp(1, 5'h09, 32'h80000304, 1, 0, VEC);
        present(F_BP | F_OV, 0, 1, 32'h80000304, 0, 1, 1);
        push_exp(1, 5'h05, 32'h80000308, 0, 32'h00000F02, VEC);
        present(F_ST, 1, 1, 32'h80000308, 32'h00000F02, 0, 1);

        // Flags without a valid instruction are ignored
        present(F_OV | F_SYS, 1, 0, 32'h80000400, 32'h5, 0, 3);

        // Exception at exception level still taken
        status_i = 32'h00400403;
        push_exp(1, 5'h0C, 32'h80000500, 0, 0, VEC);
        present(F_OV, 0, 1, 32'h80000500, 0, 0, 1);
        status_i = 32'h00400400;

        // Held exception: ignored during FLUSH/REDIRECT, re-accepted once back in IDLE
        push_exp(1, 5'h0A, 32'h80000600, 0, 0, VEC);
        push_exp(1, 5'h0A, 32'h80000600, 0, 0, VEC);
        present(F_RI, 0, 1, 32'h80000600, 0, 0, 4);

        // Interrupt through the synchronizer, enabled
        status_i = 32'h00400401;
        mem_valid_i = 1'b1; mem_pc_i = 32'h80000700;
        hw_int_raw_i = 6'h01;
        for (int i = 1; i <= NS; i++) begin
            @(posedge clk);
            #1;
            check("int_early", exc_valid_o, 0);
            check("hw_int_sync", hw_int_o, (i == NS) ? 32'h1 : 32'h0);
        end
        push_exp(1, 5'h00, 32'h80000700, 0, 0, VEC);
        @(posedge clk);
        #1 clear_inputs();
        repeat (4) @(posedge clk);
        #1;

        // Interrupt masked by IE=0: no event while the line stays high
        status_i = 32'h00400400;
        mem_valid_i = 1'b1; mem_pc_i = 32'h80000800;
        repeat (6) @(posedge clk);
        #1 clear_inputs();
        hw_int_raw_i = 6'h00;
        repeat (NS + 3) @(posedge clk);
        #1;
        check("int_cleared", hw_int_o, 0);

        // Reset during FLUSH aborts the sequence
        mem_valid_i = 1'b1; ov_i = 1'b1; mem_pc_i = 32'h80000900;
        @(posedge clk);
        #1 rst = 1'b1;
        clear_inputs();
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("abort_redir", redirect_valid_o, 0);
            check("abort_flush", flush_o, 0);
            check("abort_commit", {exc_valid_o, eret_o}, 0);
            check("abort_redir_pc", redirect_pc_o, 0);
        end

        // First edge after reset release accepts an event
        rst = 1'b1;
        mem_valid_i = 1'b1; sys_i = 1'b1; mem_pc_i = 32'h80000A00;
        push_exp(1, 5'h08, 32'h80000A00, 0, 0, VEC);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 clear_inputs();
        check("first_after_rst", exc_valid_o, 1);
        repeat (4) @(posedge clk);
        #1;

        check("exp_drained", exp_q.size(), 0);
        check("redir_pending", redir_due, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
